// File: rtl/fb_pkg.sv
// fb_pkg: shared constants and types for the framebuffer blit arbiter
package fb_pkg;
  localparam int FB_W = 240;
  localparam int FB_H = 160;
  localparam int ADDR_W = 19;
  localparam int PIX_W = 24;
  localparam int DIM_W = 6;
  localparam logic [PIX_W-1:0] KEY = 24'hFF00FF;
  typedef struct packed {
    logic [ADDR_W-1:0] src_base;
    logic [7:0]        x;
    logic [7:0]        y;
    logic [DIM_W-1:0]  w;
    logic [DIM_W-1:0]  h;
  } blit_req_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} blit_state_e;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant, pointer advances only on accept
module rr_arbiter2 (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);
  logic last_q, last_d;
  always_comb begin
    grant = &req ? (last_q ? 2'b01 : 2'b10) : req;
    last_d = accept ? grant[1] : last_q;
  end
  always_ff @(posedge Clk) begin
    last_q <= Reset ? 1'b1 : last_d;
  end
endmodule

// File: rtl/fb_blit_arbiter.sv
// fb_blit_arbiter: round-robin blit sequencer writing clipped, colour-keyed pixels to the framebuffer
module fb_blit_arbiter
  import fb_pkg::*;
(
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][ADDR_W-1:0] req_src_base,
  input  logic [1:0][7:0]        req_x,
  input  logic [1:0][7:0]        req_y,
  input  logic [1:0][DIM_W-1:0]  req_w,
  input  logic [1:0][DIM_W-1:0]  req_h,
  output logic [1:0]             done,
  output logic                   busy,
  output logic [ADDR_W-1:0]      src_addr,
  input  logic [PIX_W-1:0]       src_data,
  output logic [ADDR_W-1:0]      fb_addr,
  output logic [PIX_W-1:0]       fb_data,
  output logic                   fb_we
);
  blit_state_e state_q, state_d;
  blit_req_t job_q, job_d;
  logic g_q, g_d, pv_q, pv_d, accept, gi, run, last_col, last;
  logic [1:0] grant;
  logic [DIM_W-1:0] row_q, row_d, col_q, col_d;
  logic [8:0] dx_q, dx_d, dy_q, dy_d;
  logic [2*DIM_W-1:0] offs;
  rr_arbiter2 u_rr (
    .Clk(Clk),
    .Reset(Reset),
    .req(req_valid),
    .accept(accept),
    .grant(grant)
  );
  assign gi = grant[1];
  assign run = state_q == RUN;
  assign accept = state_q == IDLE && |req_valid && !Reset;
  assign last_col = col_q == job_q.w - DIM_W'(1);
  assign last = last_col && row_q == job_q.h - DIM_W'(1);
  assign offs = row_q * job_q.w;
  always_comb begin
    job_d = accept ? {req_src_base[gi], req_x[gi], req_y[gi], req_w[gi], req_h[gi]} : job_q;
    g_d = accept ? gi : g_q;
    state_d = accept ? ((req_w[gi] == '0 || req_h[gi] == '0) ? DONE : RUN)
            : run ? (last ? DRAIN : RUN)
            : state_q == DRAIN ? DONE : IDLE;
    col_d = (accept || (run && last_col)) ? '0 : run ? col_q + DIM_W'(1) : col_q;
    row_d = accept ? '0 : (run && last_col) ? row_q + DIM_W'(1) : row_q;
    pv_d = run;
    dx_d = 9'(job_q.x) + 9'(col_q);
    dy_d = 9'(job_q.y) + 9'(row_q);
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      job_q <= '0;
      g_q <= 1'b0;
      row_q <= '0;
      col_q <= '0;
      pv_q <= 1'b0;
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      state_q <= state_d;
      job_q <= job_d;
      g_q <= g_d;
      row_q <= row_d;
      col_q <= col_d;
      pv_q <= pv_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end
  assign req_ready = accept ? grant : 2'b00;
  assign busy = state_q != IDLE || accept;
  assign done = state_q == DONE ? (g_q ? 2'b10 : 2'b01) : 2'b00;
  assign src_addr = run ? job_q.src_base + ADDR_W'(offs) + ADDR_W'(col_q) : '0;
  assign fb_addr = pv_q ? ADDR_W'({dy_q, 8'b0}) - ADDR_W'({dy_q, 4'b0}) + ADDR_W'(dx_q) : '0;
  assign fb_data = pv_q ? src_data : '0;
  assign fb_we = pv_q && dx_q < 9'(FB_W) && dy_q < 9'(FB_H) && src_data != KEY;
endmodule

// File: tb/tb_fb_blit_arbiter.sv
// tb_fb_blit_arbiter: scoreboard bench for the blit arbiter with a 1-cycle source RAM model
module tb_fb_blit_arbiter;
  import fb_pkg::*;
  typedef struct {bit r; int lat;} job_t;
  typedef struct {logic [18:0] a; logic [23:0] d;} wr_t;
  typedef struct {bit r; int cyc;} dn_t;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic [1:0] req_valid = '0;
  logic [1:0] req_ready, done;
  logic [1:0][18:0] req_src_base = '0;
  logic [1:0][7:0] req_x = '0, req_y = '0;
  logic [1:0][5:0] req_w = '0, req_h = '0;
  logic busy, fb_we;
  logic [18:0] src_addr, fb_addr;
  logic [23:0] src_data = '0, fb_data;
  logic [23:0] mem [0:4095];
  int nvec = 0, nfail = 0, cyc = 0;
  bit ignore_wr = 1'b0;
  job_t exp_job[$];
  wr_t exp_wr[$];
  dn_t exp_dn[$];
  fb_blit_arbiter dut (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_src_base(req_src_base), .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
    .done(done), .busy(busy), .src_addr(src_addr), .src_data(src_data),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    src_data <= mem[src_addr[11:0]];
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic expect_job(input bit r, input int base, x, y, w, h, input bit nodone);
    job_t j;
    j.r = r;
    j.lat = nodone ? -1 : (w * h == 0 ? 1 : w * h + 2);
    exp_job.push_back(j);
    if (!nodone)
      for (int i = 0; i < h; i++)
        for (int k = 0; k < w; k++) begin
          int dx = x + k;
          int dy = y + i;
          logic [23:0] p = mem[base + i * w + k];
          if (dx < FB_W && dy < FB_H && p != KEY) exp_wr.push_back('{19'(dy * FB_W + dx), p});
        end
  endtask
  task automatic req(input bit r, input int base, x, y, w, h);
    int n = 0;
    @(posedge Clk);
    #1;
    req_src_base[r] = 19'(base);
    req_x[r] = 8'(x);
    req_y[r] = 8'(y);
    req_w[r] = 6'(w);
    req_h[r] = 6'(h);
    req_valid[r] = 1'b1;
    @(negedge Clk);
    while (!req_ready[r] && n < 300) begin
      @(negedge Clk);
      n++;
    end
    if (!req_ready[r]) chk("ready_timeout", 32'(req_ready), 32'(1) << r);
    @(posedge Clk);
    #1 req_valid[r] = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((exp_job.size() != 0 || exp_dn.size() != 0 || exp_wr.size() != 0 || busy) && n < 300) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 300) chk("idle_timeout", 32'(exp_wr.size() + exp_dn.size() + exp_job.size()), 0);
  endtask
  always @(negedge Clk) begin
    job_t j;
    wr_t w;
    dn_t d;
    if (!Reset) begin
      if (fb_we && !ignore_wr) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", 32'(fb_addr), 32'h7FFFFFFF);
        else begin
          w = exp_wr.pop_front();
          chk("wr_addr", 32'(fb_addr), 32'(w.a));
          chk("wr_data", 32'(fb_data), 32'(w.d));
        end
      end
      if (|req_ready) begin
        if (exp_job.size() == 0) chk("ready_unexpected", 32'(req_ready), 0);
        else begin
          j = exp_job.pop_front();
          chk("ready_grant", 32'(req_ready), 32'(1) << j.r);
          chk("busy_at_accept", 32'(busy), 1);
          if (j.lat >= 0) exp_dn.push_back('{j.r, cyc + j.lat});
        end
      end
      if (|done) begin
        if (exp_dn.size() == 0) chk("done_unexpected", 32'(done), 0);
        else begin
          d = exp_dn.pop_front();
          chk("done_vec", 32'(done), 32'(1) << d.r);
          chk("done_cycle", 32'(cyc), 32'(d.cyc));
          chk("busy_at_done", 32'(busy), 1);
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bit bad;
    for (int i = 0; i < 4096; i++) mem[i] = 24'(i + 1);
    mem[201] = KEY;
    repeat (3) @(negedge Clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_we", 32'(fb_we), 0);
    chk("rst_src_addr", 32'(src_addr), 0);
    chk("rst_fb_addr", 32'(fb_addr), 0);
    Reset = 1'b0;
    expect_job(0, 0, 5, 2, 2, 1, 0);
    expect_job(1, 300, 20, 30, 3, 2, 0);
    expect_job(0, 50, 0, 100, 1, 3, 0);
    fork
      begin
        req(0, 0, 5, 2, 2, 1);
        req(0, 50, 0, 100, 1, 3);
      end
      req(1, 300, 20, 30, 3, 2);
    join
    wait_idle();
    expect_job(0, 0, 0, 0, 2, 2, 0);
    req(0, 0, 0, 0, 2, 2);
    wait_idle();
    expect_job(1, 100, 238, 159, 4, 4, 0);
    req(1, 100, 238, 159, 4, 4);
    wait_idle();
    expect_job(0, 200, 0, 0, 2, 2, 0);
    req(0, 200, 0, 0, 2, 2);
    wait_idle();
    expect_job(1, 0, 0, 0, 0, 3, 0);
    req(1, 0, 0, 0, 0, 3);
    wait_idle();
    expect_job(0, 400, 10, 10, 3, 3, 0);
    req(0, 400, 10, 10, 3, 3);
    req_valid[1] = 1'b1;
    repeat (3) @(posedge Clk);
    #1 req_valid[1] = 1'b0;
    wait_idle();
    expect_job(0, 0, 0, 0, 16, 16, 1);
    ignore_wr = 1'b1;
    req(0, 0, 0, 0, 16, 16);
    repeat (10) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("midrst_we", 32'(fb_we), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    Reset = 1'b0;
    ignore_wr = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      @(negedge Clk);
      if (fb_we || |done || busy) bad = 1'b1;
    end
    chk("post_rst_quiet", 32'(bad), 0);
    expect_job(1, 10, 100, 50, 3, 1, 0);
    req(1, 10, 100, 50, 3, 1);
    wait_idle();
    chk("left_jobs", 32'(exp_job.size()), 0);
    chk("left_writes", 32'(exp_wr.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
